// File: rtl/draw_sched_pkg.sv
// Shared types and constants for the draw scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: scheduler state enum, client index constants, default erase colour.
package draw_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ERASE = 2'd1,
    ST_MOVE  = 2'd2,
    ST_DRAW  = 2'd3
  } state_t;

  // Client slot order within a pass: platform first, bricks last.
  localparam int CL_PLAT  = 0;
  localparam int CL_BALL  = 1;
  localparam int CL_BRICK = 2;

  localparam logic [2:0] DEF_ERASE_COLOUR = 3'b000;

endpackage

// File: rtl/draw_mux.sv
// Selects the active client's pixel onto the shared VGA write port.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the port is all-zero when no slot is active.
// Ports: slot/active/erase select the source; cl_* are the packed client
//        buses; x/y/colour/wren form the write port.
module draw_mux
  import draw_sched_pkg::*;
#(
  parameter int         NUM_CL       = CL_BRICK + 1,
  parameter logic [2:0] ERASE_COLOUR = DEF_ERASE_COLOUR
) (
  input  logic [1:0]          slot,
  input  logic                active,
  input  logic                erase,
  input  logic [10*NUM_CL-1:0] cl_x,
  input  logic [10*NUM_CL-1:0] cl_y,
  input  logic [3*NUM_CL-1:0]  cl_colour,
  input  logic [NUM_CL-1:0]    cl_wren,
  output logic [9:0]           x,
  output logic [9:0]           y,
  output logic [2:0]           colour,
  output logic                 wren
);

  always_comb begin
    x      = '0;
    y      = '0;
    colour = '0;
    wren   = 1'b0;
    if (active) begin
      for (int i = 0; i < NUM_CL; i++) begin
        if (slot == 2'(i)) begin
          x      = cl_x[10*i +: 10];
          y      = cl_y[10*i +: 10];
          // Erase passes repaint the client's pixels in the background colour.
          colour = erase ? ERASE_COLOUR : cl_colour[3*i +: 3];
          wren   = cl_wren[i];
        end
      end
    end
  end

endmodule

// File: rtl/draw_scheduler.sv
// Frame sequencer: erase every client, one move cycle, then redraw every client.
// Latency: frame_tick -> first cl_draw pulse one cycle later; write port follows the
//          selected client with zero latency.
// Backpressure: each slot waits for its client's cl_done; ticks while busy are
//          dropped and flagged on overrun. Optional per-slot watchdog is compiled in
//          with DRAW_SCHED_TIMEOUT_EN (otherwise timeout_err is tied low).
// Ports: clk/reset; frame_tick, clr_flags; packed client buses cl_x/cl_y/cl_colour/
//        cl_wren/cl_done; cl_draw and move_en strobes; x/y/colour/writeEn write port;
//        busy/frame_done status; sticky overrun/timeout_err.
module draw_scheduler
  import draw_sched_pkg::*;
#(
  parameter int         NUM_CL       = CL_BRICK + 1,
  parameter logic [2:0] ERASE_COLOUR = DEF_ERASE_COLOUR,
  parameter int         TIMEOUT      = 2047
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 frame_tick,
  input  logic                 clr_flags,
  input  logic [10*NUM_CL-1:0] cl_x,
  input  logic [10*NUM_CL-1:0] cl_y,
  input  logic [3*NUM_CL-1:0]  cl_colour,
  input  logic [NUM_CL-1:0]    cl_wren,
  input  logic [NUM_CL-1:0]    cl_done,
  output logic [NUM_CL-1:0]    cl_draw,
  output logic                 move_en,
  output logic [9:0]           x,
  output logic [9:0]           y,
  output logic [2:0]           colour,
  output logic                 writeEn,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 overrun,
  output logic                 timeout_err
);

  localparam logic [1:0] FIRST_SLOT = 2'(CL_PLAT);
  localparam logic [1:0] LAST_SLOT  = 2'(NUM_CL - 1);

  state_t              state_q, state_d;
  logic [1:0]          slot_q, slot_d;
  logic                enter;      // a new slot starts on the coming edge
  logic                fdone_d;
  logic [NUM_CL-1:0]   draw_q;
  logic                fdone_q;
  logic                overrun_q;
  logic                in_slot;
  logic                sel_done;
  logic                to_hit;
  logic                advance;

  assign in_slot = (state_q == ST_ERASE) || (state_q == ST_DRAW);

  // Only the selected client's done counts; others are ignored.
  always_comb begin
    sel_done = 1'b0;
    for (int i = 0; i < NUM_CL; i++) begin
      if (slot_q == 2'(i)) sel_done = cl_done[i];
    end
  end

  assign advance = in_slot && (sel_done || to_hit);

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    enter   = 1'b0;
    fdone_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (frame_tick) begin
          state_d = ST_ERASE;
          slot_d  = FIRST_SLOT;
          enter   = 1'b1;
        end
      end
      ST_ERASE, ST_DRAW: begin
        if (advance) begin
          if (slot_q == LAST_SLOT) begin
            slot_d = FIRST_SLOT;
            if (state_q == ST_ERASE) begin
              state_d = ST_MOVE;
            end else begin
              state_d = ST_IDLE;
              fdone_d = 1'b1;
            end
          end else begin
            slot_d = slot_q + 2'd1;
            enter  = 1'b1;
          end
        end
      end
      ST_MOVE: begin
        state_d = ST_DRAW;
        slot_d  = FIRST_SLOT;
        enter   = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        slot_d  = FIRST_SLOT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      slot_q    <= FIRST_SLOT;
      draw_q    <= '0;
      fdone_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      // Start strobe lands in the first cycle of the slot being entered.
      draw_q  <= enter ? (NUM_CL'(1) << slot_d) : '0;
      fdone_q <= fdone_d;
      // A tick arriving while busy is dropped; setting beats clearing.
      if (frame_tick && (state_q != ST_IDLE)) overrun_q <= 1'b1;
      else if (clr_flags)                     overrun_q <= 1'b0;
    end
  end

`ifdef DRAW_SCHED_TIMEOUT_EN
  localparam logic [11:0] TO_LAST = 12'(TIMEOUT - 1);

  logic [11:0] to_cnt_q;
  logic        timeout_q;

  // Counter reads 0 in a slot's first cycle, so TO_LAST marks its TIMEOUT-th cycle.
  assign to_hit = in_slot && !sel_done && (to_cnt_q == TO_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (enter)        to_cnt_q <= '0;
      else if (in_slot) to_cnt_q <= to_cnt_q + 12'd1;
      if (to_hit)         timeout_q <= 1'b1;
      else if (clr_flags) timeout_q <= 1'b0;
    end
  end

  assign timeout_err = timeout_q;
`else
  assign to_hit      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign cl_draw    = draw_q;
  assign move_en    = (state_q == ST_MOVE);
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = fdone_q;
  assign overrun    = overrun_q;

  draw_mux #(
    .NUM_CL       (NUM_CL),
    .ERASE_COLOUR (ERASE_COLOUR)
  ) u_mux (
    .slot      (slot_q),
    .active    (in_slot),
    .erase     (state_q == ST_ERASE),
    .cl_x      (cl_x),
    .cl_y      (cl_y),
    .cl_colour (cl_colour),
    .cl_wren   (cl_wren),
    .x         (x),
    .y         (y),
    .colour    (colour),
    .wren      (writeEn)
  );

endmodule
